instr_fetch: RTL and testbench

Instruction fetch stage between `program_memory` and the decoder. Holds the program counter and drives the memory's address and enable each cycle. Captures the combinational read word into a 2-entry instruction queue. Presents instructions to decode over a valid/ready handshake, and supports start, branch redirect with queue flush, and self-halt on a HALT opcode.

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC, program-memory request and 2-entry instruction queue feeding
//            decode over valid/ready; start, branch redirect/flush, self-halt.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter int         N       = 4,
    parameter int         M       = 16,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    output logic [N-1:0] pm_address,
    output logic         pm_enable,
    input  logic [M-1:0] pm_data,
    input  logic         br_valid,
    input  logic [N-1:0] br_target,
    output logic         ir_valid,
    input  logic         ir_ready,
    output logic [M-1:0] ir_data,
    output logic [N-1:0] ir_pc,
    output logic         halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [N-1:0] c_PC_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_pc;
    logic [1:0]   r_count;
    logic [M-1:0] r_head_data;
    logic [N-1:0] r_head_pc;
    logic [M-1:0] r_tail_data;
    logic [N-1:0] r_tail_pc;

    logic w_fetch;
    logic w_redirect;
    logic w_deq;

    assign w_deq = (r_count != 2'd0) && ir_ready;

    // Redirect outranks both halt detection and fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        w_redirect  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (br_valid) begin
                    w_redirect = 1'b1;
                end else if (r_count != 2'd2) begin
                    w_fetch = 1'b1;
                    if (pm_data[M-1 -: 4] == HALT_OP) w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (br_valid) begin
                    w_redirect  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_count <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect)   r_pc <= br_target;
            else if (w_fetch) r_pc <= r_pc + c_PC_ONE;

            if (w_redirect)             r_count <= 2'd0;
            else if (w_fetch && !w_deq) r_count <= r_count + 2'd1;
            else if (w_deq && !w_fetch) r_count <= r_count - 2'd1;
        end
    end

    // Head always sits in r_head_*; a dequeue shifts the tail forward.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_head_data <= '0;
            r_head_pc   <= '0;
            r_tail_data <= '0;
            r_tail_pc   <= '0;
        end else if (!w_redirect) begin
            if (w_fetch && (w_deq || r_count == 2'd0)) begin
                r_head_data <= pm_data;
                r_head_pc   <= r_pc;
            end else if (w_fetch) begin
                r_tail_data <= pm_data;
                r_tail_pc   <= r_pc;
            end else if (w_deq) begin
                r_head_data <= r_tail_data;
                r_head_pc   <= r_tail_pc;
            end
        end
    end

    assign pm_address = r_pc;
    assign pm_enable  = w_fetch;
    assign ir_valid   = (r_count != 2'd0);
    assign ir_data    = r_head_data;
    assign ir_pc      = r_head_pc;
    assign halted     = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Vector table, directed corner sequences and random stimulus
//            checked against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  pm_address;
    logic        pm_enable;
    logic [15:0] pm_data;
    logic        br_valid = 1'b0;
    logic [3:0]  br_target = 4'd0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] ir_data;
    logic [3:0]  ir_pc;
    logic        halted;

    logic [15:0] mem [16];
    assign pm_data = mem[pm_address];

    instr_fetch #(.N(4), .M(16), .HALT_OP(4'hF)) dut (
        .clk(clk), .clr_n(clr_n), .start(start),
        .pm_address(pm_address), .pm_enable(pm_enable), .pm_data(pm_data),
        .br_valid(br_valid), .br_target(br_target),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
        .ir_pc(ir_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: running/halted flags, PC, and a queue of {word, addr}.
    bit          m_run;
    bit          m_halt;
    logic [3:0]  m_pc;
    logic [19:0] m_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_pc = 4'd0; m_q.delete();
    endtask

    task automatic model_update();
        bit          fetch;
        logic [19:0] w;
        fetch = m_run && (m_q.size() < 2) && !br_valid;
        w = {mem[m_pc], m_pc};
        if ((m_q.size() != 0) && ir_ready) void'(m_q.pop_front());
        if (!m_run && !m_halt) begin
            if (start) m_run = 1;
        end else if (br_valid) begin
            m_q.delete(); m_pc = br_target; m_run = 1; m_halt = 0;
        end else if (fetch) begin
            m_q.push_back(w);
            if (mem[m_pc][15:12] == 4'hF) begin m_run = 0; m_halt = 1; end
            m_pc = 4'((int'(m_pc) + 1) % 16);
        end
    endtask

    task automatic check_model();
        chk("pm_enable", {31'd0, pm_enable}, {31'd0, m_run && (m_q.size() < 2) && !br_valid});
        chk("pm_address", {28'd0, pm_address}, {28'd0, m_pc});
        chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_q.size() != 0});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        if (m_q.size() != 0) begin
            chk("ir_data", {16'd0, ir_data}, {16'd0, m_q[0][19:4]});
            chk("ir_pc", {28'd0, ir_pc}, {28'd0, m_q[0][3:0]});
        end
    endtask

    task automatic drive(input logic st, input logic bv, input logic [3:0] bt, input logic rdy);
        start = st; br_valid = bv; br_target = bt; ir_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        drive(0, 0, 4'd0, 0);
        #1;
        model_reset();
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_pm_enable", {31'd0, pm_enable}, 32'd0);
        chk("rst_pm_address", {28'd0, pm_address}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ir_data", {16'd0, ir_data}, 32'd0);
        chk("rst_ir_pc", {28'd0, ir_pc}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        logic        st;
        logic        bv;
        logic [3:0]  bt;
        logic        rdy;
        logic        en;
        logic [3:0]  addr;
        logic        valid;
        logic [3:0]  pc;
        logic [15:0] data;
        logic        hlt;
    } vec_t;

    vec_t tbl [16];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);

        // Start/throughput, then backpressure followed by a 2-deep branch flush.
        tbl[0]  = '{1, 1, 0, 4'd0, 1, 0, 4'd0,  0, 4'd0,  16'h0000, 0};
        tbl[1]  = '{0, 0, 0, 4'd0, 1, 1, 4'd0,  0, 4'd0,  16'h0000, 0};
        tbl[2]  = '{0, 0, 0, 4'd0, 1, 1, 4'd1,  1, 4'd0,  16'h1000, 0};
        tbl[3]  = '{0, 0, 0, 4'd0, 1, 1, 4'd2,  1, 4'd1,  16'h1001, 0};
        tbl[4]  = '{1, 1, 0, 4'd0, 0, 0, 4'd0,  0, 4'd0,  16'h0000, 0};
        tbl[5]  = '{0, 0, 0, 4'd0, 0, 1, 4'd0,  0, 4'd0,  16'h0000, 0};
        tbl[6]  = '{0, 0, 0, 4'd0, 0, 1, 4'd1,  1, 4'd0,  16'h1000, 0};
        tbl[7]  = '{0, 0, 0, 4'd0, 0, 0, 4'd2,  1, 4'd0,  16'h1000, 0};
        tbl[8]  = '{0, 0, 0, 4'd0, 0, 0, 4'd2,  1, 4'd0,  16'h1000, 0};
        tbl[9]  = '{0, 0, 0, 4'd0, 1, 0, 4'd2,  1, 4'd0,  16'h1000, 0};
        tbl[10] = '{0, 0, 0, 4'd0, 0, 1, 4'd2,  1, 4'd1,  16'h1001, 0};
        tbl[11] = '{0, 0, 0, 4'd0, 0, 0, 4'd3,  1, 4'd1,  16'h1001, 0};
        tbl[12] = '{0, 0, 1, 4'd9, 1, 0, 4'd3,  1, 4'd1,  16'h1001, 0};
        tbl[13] = '{0, 0, 0, 4'd0, 1, 1, 4'd9,  0, 4'd0,  16'h0000, 0};
        tbl[14] = '{0, 0, 0, 4'd0, 1, 1, 4'd10, 1, 4'd9,  16'h1009, 0};
        tbl[15] = '{0, 0, 0, 4'd0, 1, 1, 4'd11, 1, 4'd10, 16'h100A, 0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].st, tbl[i].bv, tbl[i].bt, tbl[i].rdy);
            #1;
            chk($sformatf("v%0d_en", i), {31'd0, pm_enable}, {31'd0, tbl[i].en});
            chk($sformatf("v%0d_addr", i), {28'd0, pm_address}, {28'd0, tbl[i].addr});
            chk($sformatf("v%0d_valid", i), {31'd0, ir_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].hlt});
            if (tbl[i].valid) begin
                chk($sformatf("v%0d_pc", i), {28'd0, ir_pc}, {28'd0, tbl[i].pc});
                chk($sformatf("v%0d_data", i), {16'd0, ir_data}, {16'd0, tbl[i].data});
            end
            tick();
        end

        // PC wrap: the head after address 15 comes from address 0.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(c == 0, 0, 4'd0, 1);
            #1;
            check_model();
            if (c == 17) chk("wrap_pc15", {28'd0, ir_pc}, 32'd15);
            if (c == 18) chk("wrap_pc0", {28'd0, ir_pc}, 32'd0);
            if (c == 18) chk("wrap_data0", {16'd0, ir_data}, 32'h1000);
            tick();
        end

        // HALT at address 3, then redirect to 5.
        mem[3] = 16'hF000;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive(c == 0, c == 7, (c == 7) ? 4'd5 : 4'd0, 1);
            #1;
            check_model();
            if (c == 5) chk("halt_last_pc", {28'd0, ir_pc}, 32'd3);
            if (c == 6) chk("halt_halted", {31'd0, halted}, 32'd1);
            if (c == 6) chk("halt_no_en", {31'd0, pm_enable}, 32'd0);
            if (c == 8) chk("resume_halted", {31'd0, halted}, 32'd0);
            if (c == 8) chk("resume_addr", {28'd0, pm_address}, 32'd5);
            if (c == 8) chk("resume_en", {31'd0, pm_enable}, 32'd1);
            tick();
        end
        mem[3] = 16'h1003;

        // Asynchronous reset between edges with two words queued.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 0, 4'd0, 0);
            #1;
            check_model();
            if (c < 3) tick();
        end
        chk("pre_async_valid", {31'd0, ir_valid}, 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        model_reset();
        chk("async_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("async_pm_enable", {31'd0, pm_enable}, 32'd0);
        chk("async_halted", {31'd0, halted}, 32'd0);
        chk("async_pm_address", {28'd0, pm_address}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(c == 3, 0, 4'd0, 1);
            #1;
            check_model();
            if (c < 3) chk("post_async_no_fetch", {31'd0, pm_enable}, 32'd0);
            tick();
        end

        // Random program, start/redirect/ready traffic.
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? {4'hF, 12'($urandom)}
                                                 : {4'($urandom_range(0, 14)), 12'($urandom)};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  4'($urandom), $urandom_range(0, 3) != 0);
            #1;
            check_model();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
